seven_seg_display_arbiter: RTL
==============================

Name: seven_seg_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display (serial shifter path) among NUM_REQ producers, e.g. PC, accumulator, ALU result and debug port.
- Round-robin arbitration with a minimum dwell time per producer, so each value stays readable.
- Hands one 13-bit binary frame at a time to the display driver over a valid/ready handshake.
- Sits between the processor datapath and the seven-segment driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 50_000_000, minimum display time per grant in i_CLK cycles (>=2).
- CNT_W, 26, dwell counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- i_CLK  input  1  system clock; all state changes on the rising edge.
- i_RST_n  input  1  asynchronous active-low reset.
- i_Req  input  NUM_REQ  per-requester display request, level-sensitive.
- i_Data  input  13*NUM_REQ  flattened values; requester k occupies bits [13k+12:13k].
- i_Freeze  input  1  while high, the dwell counter holds (current grant kept).
- i_Disp_Ready  input  1  driver accepts a frame this cycle.
- o_Disp_Data  output  13  frame value to the driver.
- o_Disp_Valid  output  1  frame offered.
- o_Grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- o_Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, o_Grant=0, o_Disp_Valid=0, o_Disp_Data=0, o_Busy=0, rr pointer=0, dwell counter=0.
- States: IDLE, LOAD, DWELL. All outputs registered.
- IDLE: on the first edge with i_Req!=0:
  - Grant the first set bit searching from the rr pointer upward, wrapping.
  - Latch that requester's i_Data into o_Disp_Data and assert o_Disp_Valid.
  - Go to LOAD. Latency is 1 edge from request to grant and valid.
- LOAD: o_Disp_Data and o_Grant are held stable while o_Disp_Valid=1.
  - Transfer happens on an edge where o_Disp_Valid and i_Disp_Ready are both 1.
  - At that edge: o_Disp_Valid<=0, counter<=HOLD_CYCLES-1, go to DWELL.
  - If the granted requester drops i_Req in LOAD, the frame is still completed (no retraction). DWELL is then entered and exits on its first cycle.
- DWELL: the counter decrements once per cycle when i_Freeze=0 and holds when i_Freeze=1.
- DWELL data refresh: if the granted requester's i_Data differs from o_Disp_Data, latch the new value and re-enter LOAD with Valid=1. The counter keeps its value and is not reloaded on the following transfer.
- DWELL exit happens on the edge where counter==0, or immediately when the granted i_Req=0 (this overrides i_Freeze):
  - rr pointer <= granted index+1, mod NUM_REQ.
  - If any other requester is active, grant the next one round-robin, latch its data, Valid=1, go to LOAD (same edge, no idle gap).
  - Else if only the current requester is active, re-grant it and reload the counter. A new frame is issued only if its data differs from o_Disp_Data.
  - Else o_Grant<=0, go to IDLE. o_Disp_Data retains its last value, so the display shows the last frame.
- Simultaneous events: a refresh and an exit on the same edge are resolved in favour of the exit.
- Arbitration: a requester raising i_Req mid-dwell waits for the dwell to end. Priority order is strictly rotating, with no starvation. Worst-case wait = (NUM_REQ-1)*(HOLD_CYCLES + handshake cycles).
- Reset asserted mid-LOAD drops Valid asynchronously. The driver must tolerate an abandoned frame.

Test Plan:
- Reset, then i_Req=0 for 20 cycles -> o_Grant=0, o_Disp_Valid=0, o_Busy=0, o_Disp_Data=0.
- NUM_REQ=3, HOLD_CYCLES=8, i_Disp_Ready=1, i_Req=3'b111, data {300,200,100} -> grants rotate 001,010,100,001. Values shown are 100,200,300. Grant period is 9 cycles (1 handshake + 8 dwell).
- Back-pressure: i_Disp_Ready=0 for 5 cycles after grant -> Valid and data 100 stay constant for 5 cycles. Transfer completes on the first ready edge, then 8 dwell cycles.
- Granted requester 0 changes data 100->4095 mid-dwell -> one new frame of 4095 is issued. Total dwell is still 8 cycles from the first transfer.
- i_Freeze=1 during dwell for 10 cycles with i_Req=3'b011 -> grant stays 01 for 18 dwell cycles. Dropping i_Req[0] while frozen -> grant moves to 10 on the next edge.
- Only requester 2 active with constant data 8191 -> single frame, o_Grant=100 held, no further Valid pulses. Then assert i_RST_n=0 mid-dwell -> all outputs zero immediately.

Source files
------------

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment display among several
// producers, with a minimum dwell per grant and a valid/ready frame output.
module seven_seg_display_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_n,
    input  logic [NUM_REQ-1:0]    i_Req,
    input  logic [13*NUM_REQ-1:0] i_Data,
    input  logic                  i_Freeze,
    input  logic                  i_Disp_Ready,
    output logic [12:0]           o_Disp_Data,
    output logic                  o_Disp_Valid,
    output logic [NUM_REQ-1:0]    o_Grant,
    output logic                  o_Busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [12:0]        data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // keep_q: the dwell counter is live across LOAD (refresh frame)
    logic               keep_q, keep_d;

    function automatic logic [IDX_W-1:0] pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   start
    );
        logic [IDX_W-1:0] r;
        logic             found;
        int               k;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(start) + i) % NUM_REQ;
            if (!found && req[k]) begin
                r     = IDX_W'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] k);
        if (int'(k) >= NUM_REQ - 1) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] k);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << k;
    endfunction

    function automatic logic [12:0] data_of(
        input logic [13*NUM_REQ-1:0] d,
        input logic [IDX_W-1:0]      k
    );
        return d[13*int'(k) +: 13];
    endfunction

    logic [NUM_REQ-1:0] others;
    logic               any_other;
    logic               cur_req;
    logic [12:0]        cur_data;
    logic [IDX_W-1:0]   idle_pick;
    logic [IDX_W-1:0]   next_pick;
    logic               cnt_zero;
    logic [CNT_W-1:0]   cnt_dec;

    assign others    = i_Req & ~grant_q;
    assign any_other = |others;
    assign cur_req   = |(i_Req & grant_q);
    assign cur_data  = data_of(i_Data, gidx_q);
    assign idle_pick = pick(i_Req, rr_q);
    assign next_pick = pick(others, nxt(gidx_q));
    assign cnt_zero  = (cnt_q == '0);
    assign cnt_dec   = (i_Freeze || cnt_zero) ? cnt_q : cnt_q - 1'b1;

    // Next-state and registered-output logic for IDLE / LOAD / DWELL
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        rr_d    = rr_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        keep_d  = keep_q;
        unique case (state_q)
            IDLE: begin
                if (|i_Req) begin
                    gidx_d  = idle_pick;
                    grant_d = onehot(idle_pick);
                    data_d  = data_of(i_Data, idle_pick);
                    valid_d = 1'b1;
                    keep_d  = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (keep_q) begin
                    cnt_d = cnt_dec;
                end
                if (i_Disp_Ready) begin
                    valid_d = 1'b0;
                    state_d = DWELL;
                    if (!keep_q) begin
                        cnt_d = RELOAD;
                    end
                end
            end
            DWELL: begin
                if (cnt_zero || !cur_req) begin
                    rr_d = nxt(gidx_q);
                    if (any_other) begin
                        gidx_d  = next_pick;
                        grant_d = onehot(next_pick);
                        data_d  = data_of(i_Data, next_pick);
                        valid_d = 1'b1;
                        keep_d  = 1'b0;
                        state_d = LOAD;
                    end else if (cur_req) begin
                        cnt_d = RELOAD;
                        if (cur_data != data_q) begin
                            data_d  = cur_data;
                            valid_d = 1'b1;
                            keep_d  = 1'b1;
                            state_d = LOAD;
                        end
                    end else begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_dec;
                    if (cur_data != data_q) begin
                        data_d  = cur_data;
                        valid_d = 1'b1;
                        keep_d  = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            rr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            keep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            keep_q  <= keep_d;
        end
    end

    assign o_Disp_Data  = data_q;
    assign o_Disp_Valid = valid_q;
    assign o_Grant      = grant_q;
    assign o_Busy       = busy_q;

endmodule
